// File: rtl/cam_pkg.sv
// Shared definitions for the CAM dot-product sequencer and the state decoder.
// The state codes live here so both sides always agree on the encoding.
package cam_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_MAN_W  = 8;
    localparam int DEF_PSUM_W = 16;

    localparam logic [3:0] ST_IDLE     = 4'b0000;
    localparam logic [3:0] ST_STORE    = 4'b0001;
    localparam logic [3:0] ST_EXP_CS   = 4'b0010;
    localparam logic [3:0] ST_EXP_BIT  = 4'b0011;
    localparam logic [3:0] ST_ST_EMAX  = 4'b0100;
    localparam logic [3:0] ST_EMAX_ADD = 4'b0101;
    localparam logic [3:0] ST_FIND     = 4'b0110;
    localparam logic [3:0] ST_SHIFT    = 4'b0111;
    localparam logic [3:0] ST_PMUL     = 4'b1000;
    localparam logic [3:0] ST_PSUM     = 4'b1001;
    localparam logic [3:0] ST_DONE     = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_STORE    = ST_STORE,
        S_EXP_CS   = ST_EXP_CS,
        S_EXP_BIT  = ST_EXP_BIT,
        S_ST_EMAX  = ST_ST_EMAX,
        S_EMAX_ADD = ST_EMAX_ADD,
        S_FIND     = ST_FIND,
        S_SHIFT    = ST_SHIFT,
        S_PMUL     = ST_PMUL,
        S_PSUM     = ST_PSUM,
        S_DONE     = ST_DONE
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_seq_ctrl.sv
// Operation sequencer for the CAM floating-point dot-product datapath:
// walks store, exponent add, Emax, alignment and bit-serial multiply/accumulate.
module cam_seq_ctrl
    import cam_pkg::*;
#(
    parameter int  EXP_W  = DEF_EXP_W,
    parameter int  MAN_W  = DEF_MAN_W,
    parameter int  PSUM_W = DEF_PSUM_W,
    localparam int BW     = $clog2(max_int(EXP_W + 1, PSUM_W)),
    localparam int IW     = (MAN_W > 1) ? $clog2(MAN_W) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    input  logic          no_match,
    output logic [3:0]    state_ctrl,
    output logic [BW-1:0] bit_idx,
    output logic [IW-1:0] iter_idx,
    output logic          busy
);

    localparam logic [BW-1:0] EXP_LAST  = BW'(EXP_W - 1);
    localparam logic [BW-1:0] EMAX_LAST = BW'(EXP_W);      // extra carry/sign bit
    localparam logic [BW-1:0] PSUM_LAST = BW'(PSUM_W - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(MAN_W - 1);

    state_e state;

    // NOTE: reset is sampled on the clock edge and wins over stall/start;
    // all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_idx  <= '0;
            iter_idx <= '0;
        end else if (state == S_IDLE) begin
            if (start && !stall) state <= S_STORE;
        end else if (!stall) begin
            case (state)
                S_STORE:   state <= S_EXP_CS;
                S_EXP_CS:  state <= S_EXP_BIT;
                S_EXP_BIT: begin
                    if (bit_idx == EXP_LAST) begin
                        state   <= S_ST_EMAX;
                        bit_idx <= '0;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                S_ST_EMAX: state <= S_EMAX_ADD;
                S_EMAX_ADD: begin
                    if (bit_idx == EMAX_LAST) begin
                        state    <= S_FIND;
                        bit_idx  <= '0;
                        iter_idx <= '0;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                S_FIND: begin
                    // no_match means every row is aligned: skip the remaining shifts
                    if (no_match) begin
                        state    <= S_PMUL;
                        iter_idx <= '0;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (iter_idx == ITER_LAST) begin
                        state    <= S_PMUL;
                        iter_idx <= '0;
                    end else begin
                        state    <= S_FIND;
                        iter_idx <= iter_idx + 1'b1;
                    end
                end
                S_PMUL: state <= S_PSUM;
                S_PSUM: begin
                    if (bit_idx == PSUM_LAST) begin
                        bit_idx <= '0;
                        if (iter_idx == ITER_LAST) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_PMUL;
                            iter_idx <= iter_idx + 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: begin
                    // DONE, and recovery from any undriven code
                    state    <= S_IDLE;
                    bit_idx  <= '0;
                    iter_idx <= '0;
                end
            endcase
        end
    end

    assign state_ctrl = state;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_cam_seq_ctrl.sv
// Directed bench for cam_seq_ctrl: a schedule-list model of one operation is
// compared every cycle, with hand-computed cycle numbers pinning the model.
module tb_cam_seq_ctrl;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 8;
    localparam int PSUM_W = 16;

    localparam logic [3:0] C_IDLE = 4'b0000, C_STORE = 4'b0001, C_EXP_CS = 4'b0010,
                           C_EXP_BIT = 4'b0011, C_ST_EMAX = 4'b0100, C_EMAX_ADD = 4'b0101,
                           C_FIND = 4'b0110, C_SHIFT = 4'b0111, C_PMUL = 4'b1000,
                           C_PSUM = 4'b1001, C_DONE = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       no_match = 1'b0;
    logic [3:0] state_ctrl;
    logic [3:0] bit_idx;
    logic [2:0] iter_idx;
    logic       busy;

    cam_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .no_match   (no_match),
        .state_ctrl (state_ctrl),
        .bit_idx    (bit_idx),
        .iter_idx   (iter_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one operation is the list of (state, bit, iter) it must visit.
    typedef struct {
        logic [3:0] st;
        int         b;
        int         it;
    } ent_t;

    ent_t sched[$];
    bit   active   = 1'b0;
    int   ptr      = 0;
    int   exit_iter = -1;

    function automatic void push(input logic [3:0] st, input int b, input int it);
        ent_t e;
        e.st = st; e.b = b; e.it = it;
        sched.push_back(e);
    endfunction

    function automatic void build(input int k);
        sched.delete();
        push(C_STORE, 0, 0);
        push(C_EXP_CS, 0, 0);
        for (int b = 0; b < EXP_W; b++) push(C_EXP_BIT, b, 0);
        push(C_ST_EMAX, 0, 0);
        for (int b = 0; b <= EXP_W; b++) push(C_EMAX_ADD, b, 0);
        for (int i = 0; i < MAN_W; i++) begin
            push(C_FIND, 0, i);
            if (i == k) break;
            push(C_SHIFT, 0, i);
        end
        for (int i = 0; i < MAN_W; i++) begin
            push(C_PMUL, 0, i);
            for (int b = 0; b < PSUM_W; b++) push(C_PSUM, b, i);
        end
        push(C_DONE, 0, MAN_W - 1);
    endfunction

    function automatic void model_edge(input logic r, input logic s, input logic st);
        if (r) begin
            active = 1'b0;
        end else if (!active) begin
            if (s && !st) begin
                build(exit_iter);
                active = 1'b1;
                ptr    = 0;
            end
        end else if (!st) begin
            ptr++;
            if (ptr >= sched.size()) active = 1'b0;
        end
    endfunction

    function automatic logic [3:0] exp_st();
        return active ? sched[ptr].st : C_IDLE;
    endfunction
    function automatic int exp_bit();
        return active ? sched[ptr].b : 0;
    endfunction
    function automatic int exp_iter();
        return active ? sched[ptr].it : 0;
    endfunction

    function automatic int term_count(input logic [3:0] st);
        case (st)
            C_EXP_BIT:  return EXP_W - 1;
            C_EMAX_ADD: return EXP_W;
            C_PSUM:     return PSUM_W - 1;
            default:    return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state_ctrl", state_ctrl, exp_st());
            check("bit_idx", bit_idx, exp_bit());
            check("iter_idx", iter_idx, exp_iter());
            check("busy", busy, exp_st() != C_IDLE);
            check("illegal_code", (state_ctrl >= 4'd10) && (state_ctrl <= 4'd14), 0);
            check("bit_over_terminal", int'(bit_idx) > term_count(state_ctrl), 0);
        end
    end

    task automatic step(input logic r, input logic s, input logic st);
        rst   = r;
        start = s;
        stall = st;
        no_match = active && !st && (sched[ptr].st == C_FIND) && (sched[ptr].it == exit_iter);
        @(posedge clk);
        model_edge(r, s, st);
        #1;
    endtask

    logic [3:0] tr_state [512];
    int         tr_bit   [512];
    int         tr_iter  [512];
    int         done_count;

    task automatic record(input int cyc);
        tr_state[cyc] = state_ctrl;
        tr_bit[cyc]   = int'(bit_idx);
        tr_iter[cyc]  = int'(iter_idx);
    endtask

    // Start one operation and follow it until busy drops; cycle 1 is STORE.
    task automatic run_op(input int k, input int stall_at, input int stall_len,
                          input int rst_at, output int done_cyc, output int idle_cyc);
        int cyc;
        logic r, s, st;
        exit_iter  = k;
        done_count = 0;
        done_cyc   = -1;
        idle_cyc   = -1;
        step(1'b0, 1'b1, 1'b0);
        cyc = 1;
        record(cyc);
        while (cyc < 400) begin
            r  = (cyc == rst_at);
            s  = (cyc == 50) || (cyc == 120);
            st = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
            step(r, s, st);
            cyc++;
            record(cyc);
            if (state_ctrl == C_DONE) begin
                done_count++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
        end
        if (idle_cyc < 0) check("op_timeout_busy", busy, 0);
        exit_iter = -1;
    endtask

    int d, i;

    initial begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        cmp_en = 1'b1;
        check("reset_state", state_ctrl, C_IDLE);
        check("reset_busy", busy, 0);
        check("reset_idx", {bit_idx, iter_idx}, 0);

        // start with stall in IDLE is not accepted
        repeat (3) step(1'b0, 1'b1, 1'b1);
        check("idle_stall_start", state_ctrl, C_IDLE);
        step(1'b0, 1'b0, 1'b0);

        // full operation, no early exit
        run_op(-1, -1, 0, -1, d, i);
        check("full_done_cycle", d, 173);
        check("full_idle_cycle", i, 174);
        check("full_done_count", done_count, 1);
        check("trace_c1_store", tr_state[1], C_STORE);
        check("trace_c2_exp_cs", tr_state[2], C_EXP_CS);
        check("trace_c10_exp_bit7", {tr_state[10], 4'(tr_bit[10])}, {C_EXP_BIT, 4'd7});
        check("trace_c11_st_emax", tr_state[11], C_ST_EMAX);
        check("trace_c20_emax_bit8", {tr_state[20], 4'(tr_bit[20])}, {C_EMAX_ADD, 4'd8});
        check("trace_c21_find", tr_state[21], C_FIND);
        check("trace_c36_shift7", {tr_state[36], 4'(tr_iter[36])}, {C_SHIFT, 4'd7});
        check("trace_c37_pmul0", {tr_state[37], 4'(tr_iter[37])}, {C_PMUL, 4'd0});
        check("trace_c172_psum15", {tr_state[172], 4'(tr_bit[172])}, {C_PSUM, 4'd15});
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // early exit on the third FIND
        run_op(2, -1, 0, -1, d, i);
        check("early_done_cycle", d, 162);
        check("early_c25_find2", {tr_state[25], 4'(tr_iter[25])}, {C_FIND, 4'd2});
        check("early_c26_pmul0", {tr_state[26], 4'(tr_iter[26])}, {C_PMUL, 4'd0});
        step(1'b0, 1'b0, 1'b0);

        // 5-cycle stall with bit_idx=4 in EXP_BIT
        run_op(-1, 7, 5, -1, d, i);
        check("stall_c7_bit4", {tr_state[7], 4'(tr_bit[7])}, {C_EXP_BIT, 4'd4});
        check("stall_c12_bit4", {tr_state[12], 4'(tr_bit[12])}, {C_EXP_BIT, 4'd4});
        check("stall_c13_bit5", tr_bit[13], 5);
        check("stall_done_cycle", d, 178);
        step(1'b0, 1'b0, 1'b0);

        // reset during PSUM of iteration 3, then a clean replay
        run_op(-1, -1, 0, 95, d, i);
        check("rst_c95_psum3", {tr_state[95], 4'(tr_iter[95])}, {C_PSUM, 4'd3});
        check("rst_idle_cycle", i, 96);
        check("rst_no_done", done_count, 0);
        check("rst_idx_clear", {tr_bit[96], tr_iter[96]}, 0);
        run_op(-1, -1, 0, -1, d, i);
        check("replay_done_cycle", d, 173);
        check("replay_idle_cycle", i, 174);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_seq_ctrl.md
# cam_seq_ctrl

Sequencer for the CAM floating-point dot-product datapath. Generates the 4-bit `state_ctrl` code consumed by the state decoder, which expands it into one-hot datapath strobes. Walks one complete operation: data store, bit-serial exponent add, Emax extraction, mantissa alignment, bit-serial partial products and partial-sum accumulation. Provides the bit and iteration indices that the bit-serial steps use.

## Interface
- `EXP_W`, 8: exponent width; bit-serial exponent-add length.
- `MAN_W`, 8: mantissa width; number of alignment and multiply iterations.
- `PSUM_W`, 16: cycles per partial-sum output step.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin operation; sampled only in IDLE.
- `stall` in 1: freeze state and counters while high.
- `no_match` in 1: CAM search result in FIND; 1 = no row needs further shift.
- `state_ctrl` out 4: current state code (registered).
- `bit_idx` out BW: bit position within a bit-serial step, BW = $clog2(max(EXP_W+1, PSUM_W)).
- `iter_idx` out IW: alignment/multiply iteration, IW = $clog2(MAN_W).
- `busy` out 1: high in every state except IDLE.

## Operation
- State codes: IDLE 0000, STORE 0001, EXP_CS 0010, EXP_BIT 0011, ST_EMAX 0100, EMAX_ADD 0101, FIND 0110, SHIFT 0111, PMUL 1000, PSUM 1001, DONE 1111. Codes 1010–1110 are never driven.
- IDLE: `start`=1 and `stall`=0 → STORE. Otherwise hold.
- STORE → EXP_CS → EXP_BIT. Each of STORE and EXP_CS lasts 1 cycle.
- EXP_BIT: `bit_idx` runs 0..EXP_W-1, LSB first. After the last bit → ST_EMAX.
- ST_EMAX (1 cycle) → EMAX_ADD.
- EMAX_ADD: `bit_idx` runs 0..EXP_W; the extra bit is the carry/sign. Then → FIND with `iter_idx`=0.
- FIND: if `no_match`=1 → PMUL with `iter_idx`=0 (early exit). Otherwise → SHIFT.
- SHIFT: if `iter_idx`=MAN_W-1 → PMUL with `iter_idx`=0. Otherwise increment `iter_idx` → FIND.
- PMUL (1 cycle) → PSUM.
- PSUM: `bit_idx` runs 0..PSUM_W-1. At the end:
  - `iter_idx`=MAN_W-1 → DONE.
  - Otherwise increment `iter_idx` → PMUL.
- DONE: 1 cycle → IDLE. `iter_idx` and `bit_idx` clear.
- `bit_idx` clears on every state change. `iter_idx` changes only at the points listed above.
- `stall`=1 in any non-IDLE state: everything holds. `no_match` is ignored during a stall.
- `start` while busy: ignored, no queuing.

## Timing
- Reset values: `state_ctrl`=0000, `bit_idx`=0, `iter_idx`=0, `busy`=0.
- `rst` mid-operation → IDLE on the next edge. No partial completion.
- `rst` has priority over `stall` and `start`.
- All outputs are registered; `busy` is decoded from the state register.
- Cycle numbering for defaults, no stall, no early exit (start sampled high in cycle 0):
  - STORE 1, EXP_CS 2, EXP_BIT 3–10, ST_EMAX 11, EMAX_ADD 12–20.
  - FIND/SHIFT alternate 21–36.
  - PMUL/PSUM 37–172.
  - DONE 173, IDLE 174.
- Total busy = 4 + EXP_W + (EXP_W+1) + 2·MAN_W + MAN_W·(1+PSUM_W).
- Early exit at iteration k: FIND of iteration k is the last alignment cycle, and PMUL follows in the next cycle. This saves 2·(MAN_W-k)-1 cycles.
- A new `start` is accepted at the earliest in the IDLE cycle after DONE.

## Structure
- Shared package `cam_pkg` holds:
  - the state-code localparams, shared with the state decoder so the codes stay consistent;
  - the default `EXP_W`, `MAN_W` and `PSUM_W` constants.
- Single module with one state register, one `bit_idx` counter and one `iter_idx` counter. No sub-module. Terminal-count compare is inline per state.

## Test plan
- Reset then `start` pulse with defaults, `no_match`=0 → exact state trace per the Timing list; `state_ctrl`=1111 in cycle 173 only; `busy` low from cycle 174.
- `no_match`=1 on the third FIND (`iter_idx`=2) → next state PMUL, `iter_idx`=0, DONE in cycle 173-11=162.
- `stall` high for 5 cycles while in EXP_BIT with `bit_idx`=4 → `bit_idx` held at 4; DONE delayed by exactly 5 cycles.
- `rst` asserted during PSUM (`iter_idx`=3) → next cycle `state_ctrl`=0000, both indices 0, `busy`=0. A following `start` replays the full trace.
- `start` pulses during busy and with `stall`=1 in IDLE → no effect. Checker asserts codes 1010–1110 never appear and `bit_idx` never exceeds its step's terminal count.
